// File: rtl/instruction_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// Drives the instruction memory address from the PC and picks the next PC.
// Next-PC priority: taken branch, then jump, then stall hold, then PC+4.
// Also slices the latched instruction into its decoded fields.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pcSrc,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [5:0]  op_code,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_ext,
  output logic [31:0] jumpTarget,
  output logic        misaligned
);

  logic [31:0] pcPlus4;
  logic        jumpTaken;
  logic        redirect;
  logic [31:0] nextPc;

  // Memory is read combinationally, so the fetch address is simply the PC.
  assign imem_addr = pc;

  // Sequential successor; wraps naturally modulo 2^32.
  assign pcPlus4 = pc + 32'd4;

  // A jump decoded from a bubble is meaningless, so only a valid IF/ID slot may redirect.
  assign jumpTaken = jump && if_valid;
  assign redirect  = pcSrc || jumpTaken;

  // Jump target is formed from the upper nibble of the jump's own PC+4.
  assign jumpTarget = {if_pc4[31:28], if_instr[25:0], 2'b00};

  // Next-PC selection; the branch belongs to an older instruction, so it beats the jump.
  always_comb begin
    nextPc = pcPlus4;
    if (pcSrc) begin
      nextPc = branchTarget;
    end else if (jumpTaken) begin
      nextPc = jumpTarget;
    end else if (stall) begin
      nextPc = pc;
    end
  end

  // PC register; a redirect always wins over a hazard stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= nextPc;
    end
  end

  // IF/ID register: flush on redirect, hold on stall, otherwise capture the fetched word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_instr <= NOP_WORD;
      if_pc4   <= 32'd0;
      if_valid <= 1'b0;
    end else if (redirect) begin
      if_instr <= NOP_WORD;
      if_pc4   <= pcPlus4;
      if_valid <= 1'b0;
    end else if (!stall) begin
      if_instr <= imem_data;
      if_pc4   <= pcPlus4;
      if_valid <= 1'b1;
    end
  end

  // Field decode is pure wiring off the latched instruction.
  assign op_code = if_instr[31:26];
  assign rs      = if_instr[25:21];
  assign rt      = if_instr[20:16];
  assign rd      = if_instr[15:11];
  assign shamt   = if_instr[10:6];
  assign funct   = if_instr[5:0];
  assign imm_ext = {{16{if_instr[15]}}, if_instr[15:0]};

  // Alignment is reported only; the PC still advances normally.
  assign misaligned = (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the fetch rules.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        pcSrc = 1'b0;
  logic [31:0] branchTarget = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] pc;
  logic [31:0] ifInstr;
  logic [31:0] ifPc4;
  logic        ifValid;
  logic [5:0]  opCode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] immExt;
  logic [31:0] jumpTarget;
  logic        misaligned;

  // One planted word in an otherwise address-tagged memory.
  logic        ovrEn = 1'b0;
  logic [31:0] ovrAddr = 32'd0;
  logic [31:0] ovrWord = 32'd0;

  int total = 0;
  int bad = 0;

  // Reference model state: what the IF stage should hold after each edge.
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPc4;
  logic        mValid;

  instruction_fetch #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pcSrc(pcSrc),
    .branchTarget(branchTarget), .jump(jump),
    .imem_addr(imemAddr), .imem_data(imemData),
    .pc(pc), .if_instr(ifInstr), .if_pc4(ifPc4), .if_valid(ifValid),
    .op_code(opCode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm_ext(immExt), .jumpTarget(jumpTarget), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  assign imemData = (ovrEn && imemAddr == ovrAddr) ? ovrWord : {~imemAddr[15:0], imemAddr[15:0]};

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (ovrEn && a == ovrAddr) return ovrWord;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic modelReset();
    mPc = RESET_PC; mInstr = NOP_WORD; mPc4 = 32'd0; mValid = 1'b0;
  endtask

  // Advance the model by one edge using the current inputs, then step the clock.
  task automatic cycle();
    logic [31:0] seqPc;
    logic [31:0] fetched;
    logic [31:0] jt;
    seqPc = mPc + 32'd4;
    fetched = memWord(mPc);
    jt = {mPc4[31:28], mInstr[25:0], 2'b00};
    if (rst_n) begin
      if (pcSrc || (jump && mValid)) begin
        mPc = pcSrc ? branchTarget : jt;
        mInstr = NOP_WORD; mValid = 1'b0; mPc4 = seqPc;
      end else if (!stall) begin
        mInstr = fetched; mPc4 = seqPc; mValid = 1'b1; mPc = seqPc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic j, input logic [31:0] bt);
    stall = s; pcSrc = p; jump = j; branchTarget = bt;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #2;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (pc !== RESET_PC) begin bad++; $display("[TB] FAIL reset_pc got=%h want=%h", pc, RESET_PC); end
    total++; if (ifInstr !== NOP_WORD) begin bad++; $display("[TB] FAIL reset_instr got=%h want=%h", ifInstr, NOP_WORD); end
    total++; if (ifPc4 !== 32'd0) begin bad++; $display("[TB] FAIL reset_pc4 got=%h want=0", ifPc4); end
    total++; if (ifValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", ifValid); end
    total++; if (imemAddr !== RESET_PC) begin bad++; $display("[TB] FAIL reset_imem_addr got=%h want=%h", imemAddr, RESET_PC); end
  endtask

  task automatic test_sequential();
    resetDut();
    cycle();
    total++; if (pc !== 32'h4 || ifInstr !== 32'hFFFF_0000 || ifPc4 !== 32'h4 || ifValid !== 1'b1) begin
      bad++; $display("[TB] FAIL seq_edge1 got pc=%h instr=%h pc4=%h v=%b want 4/ffff0000/4/1", pc, ifInstr, ifPc4, ifValid); end
    cycle();
    total++; if (pc !== 32'h8 || ifInstr !== 32'hFFFB_0004) begin
      bad++; $display("[TB] FAIL seq_edge2 got pc=%h instr=%h want 8/fffb0004", pc, ifInstr); end
    cycle();
    total++; if (pc !== 32'hC || ifInstr !== 32'hFFF7_0008 || ifPc4 !== 32'hC) begin
      bad++; $display("[TB] FAIL seq_edge3 got pc=%h instr=%h pc4=%h want c/fff70008/c", pc, ifInstr, ifPc4); end
  endtask

  task automatic test_stall();
    resetDut();
    cycle(); cycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(); cycle();
    total++; if (pc !== 32'h8 || ifInstr !== 32'hFFFB_0004 || ifPc4 !== 32'h8 || ifValid !== 1'b1) begin
      bad++; $display("[TB] FAIL stall_hold got pc=%h instr=%h pc4=%h v=%b want 8/fffb0004/8/1", pc, ifInstr, ifPc4, ifValid); end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
    total++; if (pc !== 32'hC || ifInstr !== 32'hFFF7_0008 || ifPc4 !== 32'hC) begin
      bad++; $display("[TB] FAIL stall_resume got pc=%h instr=%h pc4=%h want c/fff70008/c", pc, ifInstr, ifPc4); end
  endtask

  task automatic test_branch();
    resetDut();
    repeat (4) cycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h40);
    cycle();
    total++; if (pc !== 32'h40 || ifValid !== 1'b0 || opCode !== 6'd0 || funct !== 6'd0 || ifPc4 !== 32'h14) begin
      bad++; $display("[TB] FAIL branch_redirect got pc=%h v=%b op=%h fn=%h pc4=%h want 40/0/0/0/14", pc, ifValid, opCode, funct, ifPc4); end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
    total++; if (pc !== 32'h44 || ifInstr !== 32'hFFBF_0040 || ifValid !== 1'b1) begin
      bad++; $display("[TB] FAIL branch_fetch got pc=%h instr=%h v=%b want 44/ffbf0040/1", pc, ifInstr, ifValid); end
  endtask

  task automatic test_jump();
    ovrEn = 1'b1; ovrAddr = 32'h4; ovrWord = 32'h0800_0010;
    resetDut();
    cycle(); cycle();
    total++; if (ifInstr !== 32'h0800_0010 || ifPc4 !== 32'h8 || jumpTarget !== 32'h40) begin
      bad++; $display("[TB] FAIL jump_target got instr=%h pc4=%h jt=%h want 08000010/8/40", ifInstr, ifPc4, jumpTarget); end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    cycle();
    total++; if (pc !== 32'h40 || ifValid !== 1'b0 || ifInstr !== NOP_WORD) begin
      bad++; $display("[TB] FAIL jump_redirect got pc=%h v=%b instr=%h want 40/0/0", pc, ifValid, ifInstr); end
    cycle();
    total++; if (pc !== 32'h44 || ifValid !== 1'b1 || ifInstr !== 32'hFFBF_0040) begin
      bad++; $display("[TB] FAIL jump_on_bubble_ignored got pc=%h v=%b instr=%h want 44/1/ffbf0040", pc, ifValid, ifInstr); end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    ovrEn = 1'b0;
  endtask

  task automatic test_combined();
    resetDut();
    cycle(); cycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
    cycle();
    total++; if (pc !== 32'h80 || ifValid !== 1'b0 || ifInstr !== NOP_WORD || ifPc4 !== 32'hC) begin
      bad++; $display("[TB] FAIL all_three got pc=%h v=%b instr=%h pc4=%h want 80/0/0/c", pc, ifValid, ifInstr, ifPc4); end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_async_reset();
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h20);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
    total++; if (pc !== 32'h24) begin bad++; $display("[TB] FAIL pre_reset_pc got=%h want=24", pc); end
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    total++; if (pc !== RESET_PC || ifValid !== 1'b0 || ifInstr !== NOP_WORD || ifPc4 !== 32'd0) begin
      bad++; $display("[TB] FAIL async_reset got pc=%h v=%b instr=%h pc4=%h want 0/0/0/0", pc, ifValid, ifInstr, ifPc4); end
    cycle();
    total++; if (pc !== RESET_PC || ifValid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_held_edge got pc=%h v=%b want 0/0", pc, ifValid); end
    rst_n = 1'b1;
    cycle();
    total++; if (pc !== 32'h4 || ifInstr !== 32'hFFFF_0000 || ifValid !== 1'b1) begin
      bad++; $display("[TB] FAIL post_reset_fetch got pc=%h instr=%h v=%b want 4/ffff0000/1", pc, ifInstr, ifValid); end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
    total++; if (pc !== 32'd0 || ifPc4 !== 32'd0 || ifInstr !== 32'h0003_FFFC || ifValid !== 1'b1) begin
      bad++; $display("[TB] FAIL pc_wrap got pc=%h pc4=%h instr=%h v=%b want 0/0/0003fffc/1", pc, ifPc4, ifInstr, ifValid); end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h102);
    cycle();
    total++; if (pc !== 32'h102 || misaligned !== 1'b1) begin
      bad++; $display("[TB] FAIL misaligned_flag got pc=%h mis=%b want 102/1", pc, misaligned); end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    cycle();
    total++; if (pc !== 32'h106 || misaligned !== 1'b1 || imemAddr !== 32'h106) begin
      bad++; $display("[TB] FAIL misaligned_advance got pc=%h mis=%b addr=%h want 106/1/106", pc, misaligned, imemAddr); end
  endtask

  task automatic checkOutput(input int n);
    total++; if (pc !== mPc || imemAddr !== mPc) begin
      bad++; $display("[TB] FAIL rand_pc cyc=%0d got pc=%h addr=%h want %h", n, pc, imemAddr, mPc); end
    total++; if (ifInstr !== mInstr || ifPc4 !== mPc4 || ifValid !== mValid) begin
      bad++; $display("[TB] FAIL rand_ifid cyc=%0d got %h/%h/%b want %h/%h/%b", n, ifInstr, ifPc4, ifValid, mInstr, mPc4, mValid); end
    total++; if ({opCode, rs, rt, rd, shamt, funct} !== mInstr || immExt !== {{16{mInstr[15]}}, mInstr[15:0]}) begin
      bad++; $display("[TB] FAIL rand_fields cyc=%0d got imm=%h want %h", n, immExt, {{16{mInstr[15]}}, mInstr[15:0]}); end
    total++; if (jumpTarget !== {mPc4[31:28], mInstr[25:0], 2'b00} || misaligned !== (mPc[1:0] != 2'b00)) begin
      bad++; $display("[TB] FAIL rand_jt cyc=%0d got jt=%h mis=%b want %h", n, jumpTarget, misaligned, {mPc4[31:28], mInstr[25:0], 2'b00}); end
  endtask

  task automatic test_random();
    resetDut();
    for (int n = 0; n < 300; n++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0, $urandom() & 32'h0000_03FF);
      cycle();
      checkOutput(n);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Scenario sequence, then the one summary line.
  initial begin
    modelReset();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_combined();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
